// File: rtl/byte_word_packer_pkg.sv
// Shared constants and FIFO entry layout for byte_word_packer.
// Entry carries a parity bit only when BYTE_WORD_PACKER_PARITY_EN is defined.
package byte_word_packer_pkg;
  localparam int BYTE_W = 8;
  localparam int WORD_W = 32;
  localparam int LANES  = 4;
  localparam int LEN_W  = 3;

  typedef struct packed {
    logic [WORD_W-1:0] word;
    logic [LEN_W-1:0]  len;
`ifdef BYTE_WORD_PACKER_PARITY_EN
    logic              par;
`endif
  } fifo_entry_t;
endpackage

// File: rtl/byte_word_packer_word_fifo.sv
// Synchronous word FIFO with wrap-bit pointers and a combinational head read
// that reads as zero while empty.
module word_fifo
  import byte_word_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push_i,
  input  fifo_entry_t entry_i,
  input  logic        pop_i,
  output fifo_entry_t head_o,
  output logic        full_o,
  output logic        empty_o
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam logic [PTR_W:0] PTR_ONE = {{PTR_W{1'b0}}, 1'b1};

  fifo_entry_t      mem_q [FIFO_DEPTH];
  logic [PTR_W:0]   wr_ptr_q;
  logic [PTR_W:0]   rd_ptr_q;
  logic             do_push;
  logic             do_pop;

  assign empty_o = (wr_ptr_q == rd_ptr_q);
  assign full_o  = (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]) &&
                   (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign head_o  = empty_o ? '0 : mem_q[rd_ptr_q[PTR_W-1:0]];

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PTR_ONE;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PTR_ONE;
    end
  end

  // Storage holds no control state, so it is left out of reset.
  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q[PTR_W-1:0]] <= entry_i;
  end
endmodule

// File: rtl/byte_word_packer.sv
// Packs a byte stream into 32-bit words (first byte in [7:0]) and queues them.
// Optional macro BYTE_WORD_PACKER_PARITY_EN adds out_par and par_err.
module byte_word_packer
  import byte_word_packer_pkg::*;
#(
  parameter int FIFO_DEPTH = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [BYTE_W-1:0]   in_data,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic                flush,
  output logic [WORD_W-1:0]   out_word,
  output logic [LEN_W-1:0]    out_len,
  output logic                out_valid,
  input  logic                out_ready,
`ifdef BYTE_WORD_PACKER_PARITY_EN
  output logic                out_par,
  output logic                par_err,
`endif
  output logic                busy
);
  logic [1:0]        byte_cnt_q, byte_cnt_d;
  logic [WORD_W-1:0] asm_q, asm_d;
  logic              flush_pend_q, flush_pend_d;
  logic              accept;
  logic              push;
  logic              fifo_full, fifo_empty;
  logic [WORD_W-1:0] merged;
  logic [LEN_W-1:0]  fill;
  fifo_entry_t       push_entry;
  fifo_entry_t       head;

  // in_ready depends only on registered state, never on out_ready.
  assign in_ready = !flush_pend_q && !(byte_cnt_q == 2'd3 && fifo_full);
  assign accept   = in_valid && in_ready;

  always_comb begin
    merged = asm_q;
    if (accept) merged[{byte_cnt_q, 3'b000} +: BYTE_W] = in_data;
    fill = {1'b0, byte_cnt_q} + {2'b00, accept};
  end

  always_comb begin
    byte_cnt_d      = fill[1:0];
    asm_d           = merged;
    flush_pend_d    = flush_pend_q;
    push            = 1'b0;
    push_entry      = '0;
    push_entry.word = merged;
    push_entry.len  = fill;
`ifdef BYTE_WORD_PACKER_PARITY_EN
    push_entry.par  = ^merged;
`endif
    if (fill == 3'd4) begin
      // A completing byte absorbs any same-cycle flush.
      push       = 1'b1;
      byte_cnt_d = 2'd0;
      asm_d      = '0;
    end else if ((flush || flush_pend_q) && fill != 3'd0) begin
      if (!fifo_full) begin
        push         = 1'b1;
        byte_cnt_d   = 2'd0;
        asm_d        = '0;
        flush_pend_d = 1'b0;
      end else begin
        flush_pend_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      byte_cnt_q   <= 2'd0;
      asm_q        <= '0;
      flush_pend_q <= 1'b0;
    end else begin
      byte_cnt_q   <= byte_cnt_d;
      asm_q        <= asm_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  word_fifo #(
    .FIFO_DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (push),
    .entry_i (push_entry),
    .pop_i   (out_ready),
    .head_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_word  = head.word;
  assign out_len   = head.len;
  assign out_valid = !fifo_empty;
  assign busy      = (byte_cnt_q != 2'd0) || flush_pend_q;

`ifdef BYTE_WORD_PACKER_PARITY_EN
  logic par_err_q;

  // Sticky until reset; only meaningful in a four-state simulator.
  always_ff @(posedge clk) begin
    if (rst)                                  par_err_q <= 1'b0;
    else if (accept && $isunknown(in_data))   par_err_q <= 1'b1;
  end

  assign out_par = head.par;
  assign par_err = par_err_q;
`endif
endmodule
